dcache_state_injector: RTL
==========================

Name: dcache_state_injector

Overview:
- Synthesizable successor to force-based tag warmup.
- Loads a functional-warmup snapshot of the DCache tag and data arrays through the arrays' normal RW0 write ports, one row per cycle, from a valid/ready stream.
- Holds the DCache in reset while loading.
- Sits between the snapshot source (host/DMA) and the tag/data SRAM port muxes; the muxes select this block while busy=1.

Parameters:
- SETS, 64, cache sets; power of 2.
- WAYS, 4, associativity.
- TAG_BITS, 22, stored tag width per way: raw tag plus 2 coherency bits.
- BLOCK_BYTES, 64, line size.
- BEAT_BYTES, 8, data-array row width per way.
- Derived localparams:
  - BEATS = BLOCK_BYTES/BEAT_BYTES (8).
  - DATA_ROWS = SETS*BEATS (512).
  - TA = clog2(SETS) (6).
  - DA = clog2(DATA_ROWS) (9).
  - DW = WAYS*BEAT_BYTES*8 (256).
  - TW = WAYS*TAG_BITS (88). Requires TW <= DW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load. Ignored unless IDLE.
- mode  in  1  sampled with start. 0 = tags only; 1 = tags then data.
- in_valid  in  1  snapshot beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_data  in  DW  row payload. Tag rows use bits [TW-1:0]; upper bits ignored.
- in_way_mask  in  WAYS  per-way write enable for this row.
- in_last  in  1  marks the final beat of the load.
- tag_addr  out  TA  tag RW0 address.
- tag_en  out  1  tag RW0 enable.
- tag_wmode  out  1  tag RW0 write.
- tag_wdata  out  TW  tag write data.
- tag_wmask  out  WAYS  tag per-way mask.
- data_addr  out  DA  data RW0 address.
- data_en  out  1  data RW0 enable.
- data_wmode  out  1  data RW0 write.
- data_wdata  out  DW  data write data.
- data_wmask  out  WAYS*BEAT_BYTES  data byte mask.
- busy  out  1  block owns the array ports.
- cache_hold  out  1  holds the DCache in reset.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky framing error; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counters 0. Writes abort immediately. A partially loaded array is not repaired.
- States: IDLE, TAG, DATA, FIN.
- IDLE: start=1 → TAG. Same edge: latch mode, clear err, busy=1, cache_hold=1.
- TAG: in_ready=1. Each accepted beat k (0..SETS-1), registered one cycle later:
  - tag_en=tag_wmode=1, tag_addr=k.
  - tag_wdata = in_data[TW-1:0], tag_wmask = in_way_mask.
  - After beat SETS-1: mode=1 → DATA; else → FIN.
- DATA: in_ready=1. Accepted beat r (0..DATA_ROWS-1), row r = set*BEATS + beat, registered one cycle later:
  - data_en=data_wmode=1, data_addr=r, data_wdata=in_data.
  - data_wmask: bit group w (BEAT_BYTES bits) = in_way_mask[w] replicated.
  - After beat DATA_ROWS-1 → FIN.
- Write enables are high only in the cycle after an acceptance. Beats with in_valid=0 produce no write; throughput is 1 row/cycle, no back-pressure beyond state.
- Framing:
  - Expected final beat: SETS-1 (mode 0) or SETS+DATA_ROWS-1 (mode 1).
  - in_last=1 on an earlier beat: that beat is still written, err=1, → FIN.
  - in_last=0 on the final beat: err=1, load completes normally.
- FIN (one cycle): last write drains. Next edge: done=1 for one cycle, busy=0, cache_hold=0, → IDLE. Minimum latency from final acceptance to done is 2 cycles.
- in_ready=0 in IDLE and FIN.
- start while busy is ignored. start and a beat in the same IDLE cycle: the beat is not accepted.
- Counters wrap only via state exit; no address aliasing.

Test Plan:
- mode=0, 64 beats, beat k carries tag pattern k, mask 4'hF, in_last on beat 63 → 64 tag writes addr 0..63, no data writes, done 2 cycles after beat 63, err=0; array way2/set5 reads 22'h5-pattern.
- mode=1, 64+512 beats, mask 4'b0101 on data rows → data_wmask 32'h00FF00FF on every data write, addr 0..511 sequential; ways 1/3 untouched.
- Random in_valid gaps (50%) → write count still 576, addresses gap-free and in order; done once.
- in_last on tag beat 10 → 11 writes, err=1, done pulse, busy=0. Next start clears err.
- rst_n low during DATA row 100 → all outputs 0 asynchronously, cache_hold=0. Fresh start reloads from tag addr 0.
- start pulsed during TAG → ignored, sequence unchanged. mode=0 final beat without in_last → err=1, done asserted.

Source files
------------

// File: rtl/dcache_state_injector.sv
// dcache_state_injector
// Streams a warmup snapshot into the DCache tag and data arrays through their
// RW0 write ports, one row per accepted beat, while holding the DCache in reset.
// Tags are loaded first (one row per set), then optionally the data array
// (BEATS rows per set). Framing errors are sticky until the next accepted start.
module dcache_state_injector #(
    parameter int SETS        = 64,
    parameter int WAYS        = 4,
    parameter int TAG_BITS    = 22,
    parameter int BLOCK_BYTES = 64,
    parameter int BEAT_BYTES  = 8,
    localparam int BEATS      = BLOCK_BYTES / BEAT_BYTES,
    localparam int DATA_ROWS  = SETS * BEATS,
    localparam int TA         = $clog2(SETS),
    localparam int DA         = $clog2(DATA_ROWS),
    localparam int DW         = WAYS * BEAT_BYTES * 8,
    localparam int TW         = WAYS * TAG_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_data,
    input  logic [WAYS-1:0]            in_way_mask,
    input  logic                       in_last,
    output logic [TA-1:0]              tag_addr,
    output logic                       tag_en,
    output logic                       tag_wmode,
    output logic [TW-1:0]              tag_wdata,
    output logic [WAYS-1:0]            tag_wmask,
    output logic [DA-1:0]              data_addr,
    output logic                       data_en,
    output logic                       data_wmode,
    output logic [DW-1:0]              data_wdata,
    output logic [WAYS*BEAT_BYTES-1:0] data_wmask,
    output logic                       busy,
    output logic                       cache_hold,
    output logic                       done,
    output logic                       err
);

    // Row counter is shared by both phases; it must cover the larger index space.
    localparam int CW = (DA > TA) ? DA : TA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_DATA = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            mode_reg, mode_next;
    logic            err_reg, err_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            done_reg;

    logic [TA-1:0]   tag_addr_reg;
    logic            tag_en_reg;
    logic [TW-1:0]   tag_wdata_reg;
    logic [WAYS-1:0] tag_wmask_reg;

    logic [DA-1:0]              data_addr_reg;
    logic                       data_en_reg;
    logic [DW-1:0]              data_wdata_reg;
    logic [WAYS*BEAT_BYTES-1:0] data_wmask_reg;
    logic [WAYS*BEAT_BYTES-1:0] data_wmask_next;

    logic accept;
    logic tag_accept;
    logic data_accept;
    logic tag_row_last;
    logic data_row_last;

    assign in_ready      = (state_reg == S_TAG) || (state_reg == S_DATA);
    assign accept        = in_valid && in_ready;
    assign tag_accept    = accept && (state_reg == S_TAG);
    assign data_accept   = accept && (state_reg == S_DATA);
    assign tag_row_last  = (cnt_reg == CW'(SETS - 1));
    assign data_row_last = (cnt_reg == CW'(DATA_ROWS - 1));

    // Each way's enable bit fans out to every byte lane of that way's slice.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_wmask
            assign data_wmask_next[gi*BEAT_BYTES +: BEAT_BYTES] = {BEAT_BYTES{in_way_mask[gi]}};
        end
    endgenerate

    // Control state register: FSM state, latched mode, sticky error, row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            mode_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
            done_reg  <= (state_reg == S_FIN);
        end
    end

    // Next-state logic: phase sequencing and framing checks on in_last.
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_TAG;
                    mode_next  = mode;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                end
            end
            S_TAG: begin
                if (accept) begin
                    // In mode 1 the last tag row is not the end of the load.
                    if (in_last && !(tag_row_last && !mode_reg)) begin
                        err_next   = 1'b1;
                        state_next = S_FIN;
                    end else if (tag_row_last) begin
                        if (!mode_reg && !in_last) begin
                            err_next = 1'b1;
                        end
                        state_next = mode_reg ? S_DATA : S_FIN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (in_last && !data_row_last) begin
                        err_next   = 1'b1;
                        state_next = S_FIN;
                    end else if (data_row_last) begin
                        if (!in_last) begin
                            err_next = 1'b1;
                        end
                        state_next = S_FIN;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Tag write port: one registered write in the cycle after each tag acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_en_reg    <= 1'b0;
            tag_addr_reg  <= '0;
            tag_wdata_reg <= '0;
            tag_wmask_reg <= '0;
        end else begin
            tag_en_reg <= tag_accept;
            if (tag_accept) begin
                tag_addr_reg  <= cnt_reg[TA-1:0];
                tag_wdata_reg <= in_data[TW-1:0];
                tag_wmask_reg <= in_way_mask;
            end
        end
    end

    // Data write port: one registered write in the cycle after each data acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_en_reg    <= 1'b0;
            data_addr_reg  <= '0;
            data_wdata_reg <= '0;
            data_wmask_reg <= '0;
        end else begin
            data_en_reg <= data_accept;
            if (data_accept) begin
                data_addr_reg  <= cnt_reg[DA-1:0];
                data_wdata_reg <= in_data;
                data_wmask_reg <= data_wmask_next;
            end
        end
    end

    assign tag_addr   = tag_addr_reg;
    assign tag_en     = tag_en_reg;
    assign tag_wmode  = tag_en_reg;
    assign tag_wdata  = tag_wdata_reg;
    assign tag_wmask  = tag_wmask_reg;
    assign data_addr  = data_addr_reg;
    assign data_en    = data_en_reg;
    assign data_wmode = data_en_reg;
    assign data_wdata = data_wdata_reg;
    assign data_wmask = data_wmask_reg;
    assign busy       = (state_reg != S_IDLE);
    assign cache_hold = (state_reg != S_IDLE);
    assign done       = done_reg;
    assign err        = err_reg;

endmodule
